qc_ldpc_sraa_encoder: RTL

- Parametrised quasi-cyclic LDPC parity generator built on shift-register-add-accumulate (SRAA) slices, with its own control FSM.
- Consumes a systematic message serially, one bit per accepted handshake, over K_BLK circulant row blocks of B bits each.
- Fetches each block's first generator row from an external generator ROM.
- Presents the C*B-bit parity word on a valid/ready output and holds it under backpressure.
- Sits between the message bit source and the codeword assembler; replaces the fixed 2x16-bit, three-row-block data path and its external controller.

---
 rtl/qc_ldpc_sraa_encoder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/qc_ldpc_sraa_encoder.sv
// Quasi-cyclic LDPC parity generator built from shift-register-add-accumulate slices.
// Each message bit XORs the current rotated generator row into the parity accumulator.
module qc_ldpc_sraa_encoder #(
  parameter int B     = 16,
  parameter int C     = 2,
  parameter int K_BLK = 3,
  localparam int CNT_W = (B > 1) ? $clog2(B) : 1,
  localparam int BLK_W = (K_BLK > 1) ? $clog2(K_BLK) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             abort,
  input  logic             info_bit,
  input  logic             info_valid,
  output logic             info_ready,
  output logic [BLK_W-1:0] gen_row_addr,
  input  logic [C*B-1:0]   gen_row,
  output logic [C*B-1:0]   parity,
  output logic             parity_valid,
  input  logic             parity_ready
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high. info_ready and parity_valid depend only on state, never on the partner's
  // valid/ready, and parity holds stable for as long as parity_valid waits on ready.

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(B - 1);
  localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(K_BLK - 1);

  state_t             state, state_next;
  logic [BLK_W-1:0]   blk, blk_next;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_next;
  logic [C*B-1:0]     g, g_next;
  logic [C*B-1:0]     acc, acc_next;
  logic               accept;

  // Every B-bit segment rotates one place toward its MSB; the top bit wraps to bit 0.
  function automatic logic [C*B-1:0] rotate_segs(input logic [C*B-1:0] v);
    logic [C*B-1:0] r;
    r = '0;
    for (int s = 0; s < C; s++) begin
      for (int i = 0; i < B; i++) begin
        r[s*B + i] = v[s*B + ((i + B - 1) % B)];
      end
    end
    return r;
  endfunction

  assign info_ready   = (state == ACCUM);
  assign parity_valid = (state == DONE);
  assign gen_row_addr = blk;
  assign parity       = acc;
  assign accept       = info_valid && info_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= LOAD;
      blk     <= '0;
      bit_cnt <= '0;
      g       <= '0;
      acc     <= '0;
    end else begin
      state   <= state_next;
      blk     <= blk_next;
      bit_cnt <= bit_cnt_next;
      g       <= g_next;
      acc     <= acc_next;
    end
  end

  always_comb begin
    state_next   = state;
    blk_next     = blk;
    bit_cnt_next = bit_cnt;
    g_next       = g;
    acc_next     = acc;
    case (state)
      LOAD: begin
        g_next     = gen_row;
        state_next = ACCUM;
      end
      ACCUM: begin
        if (accept) begin
          if (info_bit) acc_next = acc ^ g;
          g_next = rotate_segs(g);
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_next = '0;
            if (blk == LAST_BLK) begin
              blk_next   = '0;
              state_next = DONE;
            end else begin
              blk_next   = blk + BLK_W'(1);
              state_next = LOAD;
            end
          end else begin
            bit_cnt_next = bit_cnt + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (parity_ready) begin
          acc_next   = '0;
          state_next = LOAD;
        end
      end
      default: state_next = LOAD;
    endcase
    // abort wins over both the parity handshake and any accept in the same cycle.
    if (abort) begin
      state_next   = LOAD;
      blk_next     = '0;
      bit_cnt_next = '0;
      g_next       = '0;
      acc_next     = '0;
    end
  end

endmodule
